adc_discr_align_array: RTL and testbench

- Post-SERDES alignment stage for N_CHAN ADC+discriminator channel pairs, entirely in the lclk domain.
- Takes the deserialized two-lane ADC words and discriminator words, already transferred into clk.
- Provides a runtime-programmable per-channel discriminator delay, replacing the fixed compile-time delay.
- Runs an automatic bitslip training sequence against the ADC test pattern and drives per-lane bitslip pulses back to the SERDES.

---
 rtl/adc_discr_align_array.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_adc_discr_align_array.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_discr_align_array.sv
// ADC word register, per-channel programmable discriminator delay lines and a shared
// bitslip training sequencer that locks each ADC lane onto the test pattern.
module adc_discr_align_array #(
    parameter int                       N_CHAN        = 4,
    parameter int                       LANE_BITS     = 6,
    parameter int                       DISCR_BITS    = 8,
    parameter int                       DELAY_W       = 5,
    parameter logic [2*LANE_BITS-1:0]   TRAIN_PATTERN = 12'hA5C,
    parameter int                       SETTLE_CYCLES = 8,
    parameter int                       MATCH_CYCLES  = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [N_CHAN*2*LANE_BITS-1:0]      adc_words_in,
    input  logic [N_CHAN*DISCR_BITS-1:0]       discr_words_in,
    input  logic [N_CHAN*DELAY_W-1:0]          discr_delay,
    input  logic                               train_start,
    output logic [N_CHAN*2-1:0]                adc_bitslip,
    output logic [N_CHAN*2*LANE_BITS-1:0]      adc_words_out,
    output logic [N_CHAN*DISCR_BITS-1:0]       discr_words_out,
    output logic                               train_busy,
    output logic                               train_done,
    output logic [N_CHAN-1:0]                  train_fail
);

    localparam int ADC_W    = 2 * LANE_BITS;
    localparam int DEPTH    = 2 ** DELAY_W;
    localparam int SLIP_MAX = 2 * LANE_BITS;
    localparam int SLIP_W   = $clog2(SLIP_MAX + 2);
    localparam int MATCH_W  = $clog2(MATCH_CYCLES + 1);
    localparam int SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int CH_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_NEXT,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // ADC path: one register stage
    // ------------------------------------------------------------------
    logic [N_CHAN*ADC_W-1:0] adc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_q <= '0;
        end else begin
            adc_q <= adc_words_in;
        end
    end

    assign adc_words_out = adc_q;

    // ------------------------------------------------------------------
    // Discriminator delay lines, one shared write pointer
    // ------------------------------------------------------------------
    logic [DELAY_W-1:0] wr_ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CHAN; gi++) begin : g_discr
            logic [DISCR_BITS-1:0] buf_q [DEPTH];
            logic [DISCR_BITS-1:0] din;
            logic [DISCR_BITS-1:0] dout_d;
            logic [DISCR_BITS-1:0] dout_q;
            logic [DELAY_W-1:0]    dly;
            logic [DELAY_W-1:0]    rd_ptr;

            assign din    = discr_words_in[gi*DISCR_BITS +: DISCR_BITS];
            assign dly    = discr_delay[gi*DELAY_W +: DELAY_W];
            // buf_q[wr_ptr_q - k] holds the word that arrived k cycles before the current one
            assign rd_ptr = wr_ptr_q - dly;
            assign dout_d = (dly == '0) ? din : buf_q[rd_ptr];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        buf_q[i] <= '0;
                    end
                    dout_q <= '0;
                end else begin
                    buf_q[wr_ptr_q] <= din;
                    dout_q          <= dout_d;
                end
            end

            assign discr_words_out[gi*DISCR_BITS +: DISCR_BITS] = dout_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Training sequencer
    // ------------------------------------------------------------------
    state_t                       state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [SET_W-1:0]             settle_q, settle_d;
    logic [1:0][MATCH_W-1:0]      match_q, match_d;
    logic [1:0][SLIP_W-1:0]       slip_q, slip_d;
    logic [1:0]                   locked_q, locked_d;
    logic [1:0]                   mask_q, mask_d;
    logic [N_CHAN*2-1:0]          bitslip_q, bitslip_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [N_CHAN-1:0]            fail_q, fail_d;

    logic [ADC_W-1:0]             chan_word [N_CHAN];
    logic [ADC_W-1:0]             cur_word;
    logic [1:0]                   lane_match;
    logic [1:0]                   mism;
    logic                         slip_over;

    generate
        for (gi = 0; gi < N_CHAN; gi++) begin : g_chan_word
            assign chan_word[gi] = adc_words_in[gi*ADC_W +: ADC_W];
        end
        for (gi = 0; gi < 2; gi++) begin : g_lane_cmp
            assign lane_match[gi] =
                (cur_word[gi*LANE_BITS +: LANE_BITS] == TRAIN_PATTERN[gi*LANE_BITS +: LANE_BITS]);
        end
    endgenerate

    assign cur_word = chan_word[ch_q];

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        settle_d  = settle_q;
        match_d   = match_q;
        slip_d    = slip_q;
        locked_d  = locked_q;
        mask_d    = mask_q;
        busy_d    = busy_q;
        done_d    = done_q;
        fail_d    = fail_q;
        bitslip_d = '0;
        mism      = '0;
        slip_over = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (train_start) begin
                    state_d  = ST_SETTLE;
                    ch_d     = '0;
                    settle_d = '0;
                    match_d  = '0;
                    slip_d   = '0;
                    locked_d = '0;
                    mask_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    fail_d   = '0;
                end
            end

            ST_SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d  = ST_CHECK;
                    settle_d = '0;
                    for (int l = 0; l < 2; l++) begin
                        if (!locked_q[l]) begin
                            match_d[l] = '0;
                        end
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            ST_CHECK: begin
                for (int l = 0; l < 2; l++) begin
                    if (!locked_q[l]) begin
                        if (lane_match[l]) begin
                            if (match_q[l] == MATCH_W'(MATCH_CYCLES - 1)) begin
                                locked_d[l] = 1'b1;
                            end else begin
                                match_d[l] = match_q[l] + 1'b1;
                            end
                        end else begin
                            mism[l] = 1'b1;
                        end
                    end
                end
                // The slip pulse is registered, so it is high exactly while in SLIP
                if (|mism) begin
                    state_d               = ST_SLIP;
                    mask_d                = mism;
                    bitslip_d[ch_q*2 +: 2] = mism;
                end else if (&locked_d) begin
                    state_d = ST_NEXT;
                end
            end

            ST_SLIP: begin
                for (int l = 0; l < 2; l++) begin
                    if (mask_q[l]) begin
                        slip_d[l]  = slip_q[l] + 1'b1;
                        match_d[l] = '0;
                        if (slip_q[l] == SLIP_W'(SLIP_MAX)) begin
                            slip_over = 1'b1;
                        end
                    end
                end
                if (slip_over) begin
                    fail_d[ch_q] = 1'b1;
                    state_d      = ST_NEXT;
                end else begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end

            ST_NEXT: begin
                locked_d = '0;
                match_d  = '0;
                slip_d   = '0;
                mask_d   = '0;
                settle_d = '0;
                if (ch_q == CH_W'(N_CHAN - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = ST_SETTLE;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            settle_q  <= '0;
            match_q   <= '0;
            slip_q    <= '0;
            locked_q  <= '0;
            mask_q    <= '0;
            bitslip_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            settle_q  <= settle_d;
            match_q   <= match_d;
            slip_q    <= slip_d;
            locked_q  <= locked_d;
            mask_q    <= mask_d;
            bitslip_q <= bitslip_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    assign adc_bitslip = bitslip_q;
    assign train_busy  = busy_q;
    assign train_done  = done_q;
    assign train_fail  = fail_q;

endmodule

// File: tb/tb_adc_discr_align_array.sv
// Scoreboard bench: stimulus queues cycle-stamped or event-triggered expectations,
// a negedge monitor pops and compares them; a lane model answers bitslip pulses.
module tb_adc_discr_align_array;

    localparam int NC = 2;
    localparam int LB = 6;
    localparam int DB = 8;
    localparam int DW = 5;

    logic                 clk;
    logic                 reset_n;
    logic [NC*2*LB-1:0]   adc_words_in;
    logic [NC*DB-1:0]     discr_words_in;
    logic [NC*DW-1:0]     discr_delay;
    logic                 train_start;
    logic [NC*2-1:0]      adc_bitslip;
    logic [NC*2*LB-1:0]   adc_words_out;
    logic [NC*DB-1:0]     discr_words_out;
    logic                 train_busy;
    logic                 train_done;
    logic [NC-1:0]        train_fail;

    adc_discr_align_array #(
        .N_CHAN(NC), .LANE_BITS(LB), .DISCR_BITS(DB), .DELAY_W(DW),
        .TRAIN_PATTERN(12'hA5C), .SETTLE_CYCLES(8), .MATCH_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .adc_words_in   (adc_words_in),
        .discr_words_in (discr_words_in),
        .discr_delay    (discr_delay),
        .train_start    (train_start),
        .adc_bitslip    (adc_bitslip),
        .adc_words_out  (adc_words_out),
        .discr_words_out(discr_words_out),
        .train_busy     (train_busy),
        .train_done     (train_done),
        .train_fail     (train_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 discr ch0, 1 adc words, 2 all outputs zero, 3 quiet after reset, 5 timeout
    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] exp;
    } item_t;

    typedef struct {
        int         p [4];
        logic [1:0] fail;
    } texp_t;

    item_t dq[$];
    texp_t tq[$];

    int checks = 0;
    int errors = 0;
    int epoch = 0;
    int finish_req = 0;

    // Lane model: lane b shows the pattern only after need[b] slips
    int need [NC*2];
    int slips [NC*2];
    int viol = 0;
    logic [11:0]        pat_v = 12'hA5C;
    logic [LB-1:0]      model_sl;
    logic [NC*2*LB-1:0] model_word;
    logic               adc_ovr_en;
    logic [NC*2*LB-1:0] adc_ovr;

    always_comb begin
        model_word = '0;
        model_sl   = '0;
        for (int b = 0; b < NC*2; b++) begin
            model_sl = pat_v[(b % 2)*LB +: LB];
            model_word[b*LB +: LB] = (slips[b] >= need[b]) ? model_sl : (model_sl ^ 6'h15);
        end
    end

    assign adc_words_in = adc_ovr_en ? adc_ovr : model_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        int          seen_epoch;
        logic [3:0]  prev_bs;
        logic        done_prev;
        item_t       it;
        texp_t       te;
        int          tot;
        seen_epoch = 0;
        prev_bs    = '0;
        done_prev  = 1'b0;
        for (int b = 0; b < NC*2; b++) slips[b] = 0;
        forever begin
            @(negedge clk);
            if (epoch != seen_epoch) begin
                for (int b = 0; b < NC*2; b++) slips[b] = 0;
                viol       = 0;
                seen_epoch = epoch;
            end
            for (int b = 0; b < NC*2; b++) begin
                if (adc_bitslip[b]) slips[b]++;
            end
            if ((adc_bitslip & prev_bs) != 0) viol++;
            if ((|adc_bitslip[1:0]) && (|adc_bitslip[3:2])) viol++;
            prev_bs = adc_bitslip;

            while (dq.size() > 0 && dq[0].cyc <= cyc) begin
                it = dq.pop_front();
                if (it.cyc < cyc) begin
                    chk("missed_slot", 64'(it.cyc), 64'(cyc));
                end else begin
                    case (it.kind)
                        0: chk("discr_ch0", 64'(discr_words_out[DB-1:0]), 64'(it.exp[DB-1:0]));
                        1: chk("adc_out", 64'(adc_words_out), 64'(it.exp[NC*2*LB-1:0]));
                        2: chk("outputs_zero",
                               {24'b0, adc_words_out, discr_words_out, adc_bitslip,
                                train_busy, train_done, train_fail}, 64'd0);
                        3: begin
                            tot = 0;
                            for (int b = 0; b < NC*2; b++) tot += slips[b];
                            chk("no_slip_after_reset", 64'(tot), 64'd0);
                            chk("busy_after_reset", 64'(train_busy), 64'd0);
                        end
                        default: chk("train_timeout", 64'(train_done), 64'd1);
                    endcase
                end
            end

            if (train_done && !done_prev) begin
                if (tq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    te = tq.pop_front();
                    for (int b = 0; b < NC*2; b++) begin
                        chk($sformatf("pulses_bit%0d", b), 64'(slips[b]), 64'(te.p[b]));
                    end
                    chk("train_fail", 64'(train_fail), 64'(te.fail));
                    chk("busy_at_done", 64'(train_busy), 64'd0);
                    chk("pulse_shape", 64'(viol), 64'd0);
                end
            end
            done_prev = train_done;

            if (finish_req != 0) begin
                chk("leftover_expectations", 64'(dq.size() + tq.size()), 64'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int at, input logic [31:0] exp);
        item_t it;
        it.kind = kind;
        it.cyc  = at;
        it.exp  = exp;
        dq.push_back(it);
    endtask

    task automatic push_train(input int p0, input int p1, input int p2, input int p3,
                              input logic [1:0] fail);
        texp_t te;
        te.p[0] = p0; te.p[1] = p1; te.p[2] = p2; te.p[3] = p3;
        te.fail = fail;
        tq.push_back(te);
    endtask

    task automatic pulse_start();
        train_start = 1'b1;
        tick();
        train_start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!train_done && n < 3000) begin
            tick();
            n++;
        end
        if (!train_done) push(5, cyc + 1, 32'd1);
        repeat (3) tick();
    endtask

    initial begin : stim
        int m;
        int n;
        reset_n        = 1'b0;
        discr_words_in = '0;
        discr_delay    = '0;
        train_start    = 1'b0;
        adc_ovr_en     = 1'b1;
        adc_ovr        = '0;
        for (int b = 0; b < NC*2; b++) need[b] = 0;

        repeat (2) tick();
        push(2, cyc, 32'd0);
        tick();
        reset_n = 1'b1;
        push(2, cyc + 1, 32'd0);
        repeat (3) tick();

        // d = 0: latency 1
        discr_words_in[7:0] = 8'h01;
        push(0, cyc + 1, 32'h01);
        push(0, cyc + 2, 32'h00);
        tick();
        discr_words_in[7:0] = 8'h00;
        repeat (5) tick();

        // d = 31: latency 32
        discr_delay[4:0]    = 5'd31;
        discr_words_in[7:0] = 8'h80;
        push(0, cyc + 31, 32'h00);
        push(0, cyc + 32, 32'h80);
        push(0, cyc + 33, 32'h00);
        tick();
        discr_words_in[7:0] = 8'h00;
        repeat (40) tick();

        // Ramp with a tap change from 3 to 10
        discr_delay[4:0] = 5'd3;
        for (int i = 0; i < 40; i++) begin
            discr_words_in[7:0] = 8'(cyc);
            if (i == 19) push(0, cyc, 32'((cyc - 4) & 8'hFF));
            if (i == 20) begin
                m = cyc;
                discr_delay[4:0] = 5'd10;
                push(0, m,      32'((m - 4)  & 8'hFF));
                push(0, m + 1,  32'((m - 10) & 8'hFF));
                push(0, m + 2,  32'((m - 9)  & 8'hFF));
                push(0, m + 11, 32'(m & 8'hFF));
            end
            tick();
        end
        discr_words_in = '0;
        discr_delay    = '0;

        // ADC path latency
        adc_ovr = 24'h123456;
        push(1, cyc + 1, 32'h123456);
        tick();
        adc_ovr = 24'hABCDEF;
        push(1, cyc + 1, 32'hABCDEF);
        tick();
        adc_ovr_en = 1'b0;
        repeat (3) tick();

        // ch0 lane0 needs 3 slips; a second start while busy is ignored
        need[0] = 3; need[1] = 0; need[2] = 0; need[3] = 0;
        epoch++;
        repeat (2) tick();
        push_train(3, 0, 0, 0, 2'b00);
        pulse_start();
        repeat (20) tick();
        pulse_start();
        wait_done();

        // ch0 lane1 needs 2 slips, ch1 lane1 never locks
        need[0] = 0; need[1] = 2; need[2] = 0; need[3] = 99;
        epoch++;
        repeat (2) tick();
        push_train(0, 2, 0, 13, 2'b10);
        pulse_start();
        wait_done();

        // Reset while a slip pulse is on the wire
        need[0] = 99; need[1] = 0; need[2] = 0; need[3] = 0;
        epoch++;
        repeat (2) tick();
        pulse_start();
        n = 0;
        while (adc_bitslip == '0 && n < 500) begin
            tick();
            n++;
        end
        if (adc_bitslip == '0) push(5, cyc + 1, 32'd1);
        reset_n = 1'b0;
        epoch++;
        #1;
        push(2, cyc, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (30) tick();
        push(3, cyc + 1, 32'd0);
        repeat (3) tick();

        finish_req = 1;
        repeat (5) tick();
        $display("FAIL monitor did not finish");
        $fatal(1, "monitor stalled");
    end

endmodule
